// File: rtl/terminal_pkg.sv
// terminal_pkg: shared screen geometry, fill code and sequencer state encoding
package terminal_pkg;
  localparam int SCREEN_WIDTH = 80;
  localparam int SCREEN_HEIGHT = 30;
  localparam int VRAM_CELLS = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam logic [7:0] FILL_CHAR = 8'h20;
  typedef enum logic [2:0] {IDLE, CHAR_WR, CLR_FILL, SCR_RD, SCR_WR, SCR_FILL, FINISH} seq_state_t;
endpackage

// File: rtl/vram_cell_counter.sv
// vram_cell_counter: loadable address up-counter that flags when it sits on its end value
module vram_cell_counter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] start,
  input  logic [ADDR_W-1:0] stop,
  output logic [ADDR_W-1:0] cnt,
  output logic              last
);
  logic [ADDR_W-1:0] stop_q;
  assign last = cnt == stop_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      stop_q <= '0;
    end else if (load) begin
      cnt <= start;
      stop_q <= stop;
    end else if (inc) cnt <= cnt + ADDR_W'(1);
endmodule

// File: rtl/vram_access_sequencer.sv
// vram_access_sequencer: arbitrates keyboard writes, screen clear and scroll-up onto the single VRAM port
module vram_access_sequencer
  import terminal_pkg::*;
#(
  parameter int COLS = SCREEN_WIDTH,
  parameter int ROWS = SCREEN_HEIGHT,
  parameter int ADDR_W = 16,
  parameter logic [7:0] FILL_CHAR = terminal_pkg::FILL_CHAR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              clear_req,
  input  logic              scroll_req,
  output logic              busy,
  output logic              done,
  output logic              vram_we,
  output logic              vram_re,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  input  logic [7:0]        vram_rdata
);
  localparam logic [ADDR_W-1:0] CELLS = ADDR_W'(COLS * ROWS);
  localparam logic [ADDR_W-1:0] COPY = ADDR_W'(COLS * (ROWS - 1));
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  seq_state_t state;
  logic clr_p, scr_p, serv_clr, go_clr, go_scr, accept;
  logic cnt_load, cnt_inc, cnt_last;
  logic [ADDR_W-1:0] cnt, cnt_start, cnt_stop, wdata_q_ext;
  logic [7:0] wdata_q;
  assign wr_ready = state == IDLE && !clr_p && !scr_p && !clear_req && !scroll_req && !reset;
  assign accept = wr_valid && wr_ready;
  assign busy = clr_p || scr_p || (state != IDLE && state != CHAR_WR);
  assign go_clr = state == IDLE && clr_p;
  assign go_scr = state == IDLE && !clr_p && scr_p;
  assign cnt_load = go_clr || go_scr || (state == SCR_WR && cnt_last);
  assign cnt_start = state == SCR_WR ? COPY : '0;
  assign cnt_stop = go_scr ? COPY - ADDR_W'(1) : CELLS - ADDR_W'(1);
  assign cnt_inc = (state == CLR_FILL || state == SCR_FILL || state == SCR_WR) && !cnt_last;
  // read data arrives during SCR_WR, so the copy path bypasses the data register
  assign vram_wdata = state == SCR_WR ? vram_rdata : wdata_q;
  assign wdata_q_ext = '0;
  vram_cell_counter #(.ADDR_W(ADDR_W)) u_dst (
    .clk(clk), .reset(reset), .load(cnt_load), .inc(cnt_inc),
    .start(cnt_start), .stop(cnt_stop), .cnt(cnt), .last(cnt_last)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      clr_p <= 1'b0;
      scr_p <= 1'b0;
      serv_clr <= 1'b0;
      done <= 1'b0;
      vram_we <= 1'b0;
      vram_re <= 1'b0;
      vram_addr <= '0;
      wdata_q <= '0;
    end else begin
      done <= 1'b0;
      clr_p <= clear_req || (clr_p && !(state == FINISH && serv_clr));
      scr_p <= scroll_req || (scr_p && !(state == FINISH && !serv_clr));
      case (state)
        IDLE:
          if (go_clr) begin
            state <= CLR_FILL;
            serv_clr <= 1'b1;
            vram_we <= 1'b1;
            vram_addr <= wdata_q_ext;
            wdata_q <= FILL_CHAR;
          end else if (go_scr) begin
            state <= SCR_RD;
            serv_clr <= 1'b0;
            vram_re <= 1'b1;
            vram_addr <= COLS_A;
          end else if (accept && wr_addr < CELLS) begin
            state <= CHAR_WR;
            vram_we <= 1'b1;
            vram_addr <= wr_addr;
            wdata_q <= wr_data;
          end
        CHAR_WR: begin
          state <= IDLE;
          vram_we <= 1'b0;
        end
        CLR_FILL, SCR_FILL:
          if (cnt_last) begin
            state <= FINISH;
            vram_we <= 1'b0;
            done <= 1'b1;
          end else vram_addr <= cnt + ADDR_W'(1);
        SCR_RD: begin
          state <= SCR_WR;
          vram_re <= 1'b0;
          vram_we <= 1'b1;
          vram_addr <= cnt;
        end
        SCR_WR:
          if (cnt_last) begin
            state <= SCR_FILL;
            vram_addr <= COPY;
            wdata_q <= FILL_CHAR;
          end else begin
            state <= SCR_RD;
            vram_we <= 1'b0;
            vram_re <= 1'b1;
            vram_addr <= cnt + COLS_A + ADDR_W'(1);
          end
        default: state <= IDLE;
      endcase
    end
endmodule
